chip_seq_ctrl: RTL and testbench

- Command-level sequencer that drives the Master side of the chip port bundle (memristor array control, address, seed and readout lines).
- Accepts one command at a time over a valid/ready interface: SET/RESET program pulse, seed load, single-cell read, or timed stochastic inference with 8-bit readout.
- Expands each command into timed strobe sequences and returns one response per command.
- Sits between the host/test-controller logic and the chip pads.

---
 rtl/chip_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_chip_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chip_seq_ctrl.sv
// Command-level sequencer for the chip port bundle. It expands one host command
// at a time into timed program, seed, read and inference strobe sequences.
module chip_seq_ctrl #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_W   = 4,
   parameter int INF_CYC   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_row,
   input  logic [7:0] cmd_col,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       CBL,
   output logic       CSL,
   output logic       CBLEN,
   output logic       CWL,
   output logic       inference,
   output logic       load_seed,
   output logic       read_1,
   output logic       read_8,
   output logic       load_mem,
   output logic       read_out,
   output logic       stoch_log,
   output logic [7:0] addr_full_row,
   output logic [7:0] addr_full_col,
   output logic [7:0] seeds,
   input  logic [3:0] bit_out
);

   localparam int MAX_P = (SETUP_CYC > PULSE_W) ?
                          ((SETUP_CYC > INF_CYC) ? SETUP_CYC : INF_CYC) :
                          ((PULSE_W > INF_CYC) ? PULSE_W : INF_CYC);
   localparam int CNT_W = $clog2(MAX_P + 1);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] INF_LD   = CNT_W'(INF_CYC - 1);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_SET   = 3'd1;
   localparam logic [2:0] OP_RESET = 3'd2;
   localparam logic [2:0] OP_SEED  = 3'd3;
   localparam logic [2:0] OP_READ  = 3'd4;
   localparam logic [2:0] OP_INFER = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_SEED,
      S_READ, S_INFER, S_CAP0, S_CAP1, S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             set_q;
   logic             accept;
   logic             rsp_done;

   assign accept   = cmd_valid && cmd_ready;
   assign rsp_done = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Timed states leave when the down-counter reaches zero; it reloads on entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_SET, OP_RESET: state_d = S_SETUP;
                  OP_SEED:          state_d = S_SEED;
                  OP_READ:          state_d = S_READ;
                  OP_INFER:         state_d = S_INFER;
                  default:          state_d = S_RESP;
               endcase
            end
         end
         S_SETUP: if (cnt_q == '0) state_d = S_PULSE;
         S_PULSE: if (cnt_q == '0) state_d = S_HOLD;
         S_HOLD:  state_d = S_RESP;
         S_SEED:  state_d = S_RESP;
         S_READ:  if (cnt_q == '0) state_d = S_RESP;
         S_INFER: if (cnt_q == '0) state_d = S_CAP0;
         S_CAP0:  state_d = S_CAP1;
         S_CAP1:  state_d = S_RESP;
         S_RESP:  if (rsp_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) begin
         case (state_d)
            S_SETUP, S_READ: cnt_d = SETUP_LD;
            S_PULSE:         cnt_d = PULSE_LD;
            S_INFER:         cnt_d = INF_LD;
            default:         cnt_d = '0;
         endcase
      end
   end

   // Strobes are decoded from the next state so the registered pins line up with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         CBL       <= 1'b0;
         CSL       <= 1'b0;
         CBLEN     <= 1'b0;
         CWL       <= 1'b0;
         inference <= 1'b0;
         load_seed <= 1'b0;
         read_1    <= 1'b0;
         read_8    <= 1'b0;
         load_mem  <= 1'b0;
         read_out  <= 1'b0;
      end else begin
         cmd_ready <= (state_d == S_IDLE);
         rsp_valid <= (state_d == S_RESP);
         CBL       <= (state_d == S_PULSE) && set_q;
         CSL       <= (state_d == S_PULSE) && !set_q;
         CBLEN     <= (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
         CWL       <= (state_d == S_PULSE);
         inference <= (state_d == S_INFER);
         load_seed <= (state_d == S_SEED);
         read_1    <= (state_d == S_READ);
         read_8    <= (state_d == S_CAP0) || (state_d == S_CAP1);
         load_mem  <= (state_d == S_SETUP) || (state_d == S_HOLD);
         read_out  <= (state_d == S_CAP0) || (state_d == S_CAP1);
      end
   end

   // Command fields are captured at accept and held; readout nibbles land at the end of their cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_full_row <= 8'h00;
         addr_full_col <= 8'h00;
         seeds         <= 8'h00;
         stoch_log     <= 1'b0;
         set_q         <= 1'b0;
         rsp_data      <= 8'h00;
         rsp_err       <= 1'b0;
      end else begin
         if (accept) begin
            addr_full_row <= cmd_row;
            addr_full_col <= cmd_col;
            set_q         <= (cmd_op == OP_SET);
            rsp_data      <= 8'h00;
            rsp_err       <= (cmd_op > OP_INFER);
            if (cmd_op == OP_SEED)  seeds     <= cmd_data;
            if (cmd_op == OP_INFER) stoch_log <= cmd_data[0];
         end
         if (state_q == S_READ && cnt_q == '0) rsp_data <= {4'h0, bit_out};
         if (state_q == S_CAP0) rsp_data[3:0] <= bit_out;
         if (state_q == S_CAP1) rsp_data[7:4] <= bit_out;
         if (state_q == S_RESP && rsp_ready) rsp_err <= 1'b0;
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, OP_NOP};

endmodule

// File: tb/tb_chip_seq_ctrl.sv
// Self-checking bench for chip_seq_ctrl: directed test-plan steps followed by
// random commands, each checked against a per-command table of expected timing.
module tb_chip_seq_ctrl;

   localparam int S   = 2;
   localparam int P   = 4;
   localparam int INF = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_row;
   logic [7:0] cmd_col;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       CBL, CSL, CBLEN, CWL;
   logic       inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log;
   logic [7:0] addr_full_row, addr_full_col, seeds;
   logic [3:0] bit_out;

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] expSeeds = 8'h00;
   logic       expStoch = 1'b0;

   string strobeName [10] = '{"CBL", "CSL", "CBLEN", "CWL", "inference",
                              "load_seed", "read_1", "read_8", "load_mem", "read_out"};

   chip_seq_ctrl #(.SETUP_CYC(S), .PULSE_W(P), .INF_CYC(INF)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .CBL(CBL), .CSL(CSL), .CBLEN(CBLEN), .CWL(CWL),
      .inference(inference), .load_seed(load_seed), .read_1(read_1), .read_8(read_8),
      .load_mem(load_mem), .read_out(read_out), .stoch_log(stoch_log),
      .addr_full_row(addr_full_row), .addr_full_col(addr_full_col), .seeds(seeds),
      .bit_out(bit_out)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] strobes();
      return {read_out, load_mem, read_8, read_1, load_seed, inference, CWL, CBLEN, CSL, CBL};
   endfunction

   function automatic logic [45:0] allOutputs();
      return {cmd_ready, rsp_valid, rsp_data, rsp_err, strobes(), stoch_log,
              addr_full_row, addr_full_col, seeds};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full command: accept, watch every cycle until the response, optionally stall, then handshake.
   task automatic applyStimulus(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                                input logic [7:0] data, input logic [3:0] nib0, input logic [3:0] nib1,
                                input int holdCyc);
      int expLat, lat, cyc, wait_n, r1Seen, capSeen, addrErr, bothErr;
      int expCnt [10];
      int obsCnt [10];
      logic [7:0] expData;
      logic expErr, readyAtOne;
      logic [9:0] st;

      foreach (expCnt[i]) begin expCnt[i] = 0; obsCnt[i] = 0; end
      expData = 8'h00;
      expErr  = (op > 3'd5);
      expLat  = 1;
      case (op)
         3'd1, 3'd2: begin
            expLat = S + P + 2;
            expCnt[8] = S + 1; expCnt[2] = S + P + 1; expCnt[3] = P;
            if (op == 3'd1) expCnt[0] = P; else expCnt[1] = P;
         end
         3'd3: begin expLat = 2; expCnt[5] = 1; expSeeds = data; end
         3'd4: begin expLat = S + 1; expCnt[6] = S; expData = {4'h0, nib0}; end
         3'd5: begin
            expLat = INF + 3; expCnt[4] = INF; expCnt[7] = 2; expCnt[9] = 2;
            expData = {nib1, nib0}; expStoch = data[0];
         end
         default: ;
      endcase

      wait_n = 0;
      while (!cmd_ready && wait_n < 100) begin @(posedge clk); #1; wait_n++; end
      checkOutput("cmdReadyWait", 64'(cmd_ready), 64'd1);

      cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data;
      cmd_valid = 1'b1;
      bit_out = ~nib0;
      cyc = 0; lat = 0; r1Seen = 0; capSeen = 0; addrErr = 0; bothErr = 0; readyAtOne = 1'b1;
      while (lat == 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin cmd_valid = 1'b0; readyAtOne = cmd_ready; end
         st = strobes();
         foreach (obsCnt[i]) if (st[i]) obsCnt[i]++;
         if (addr_full_row !== row || addr_full_col !== col) addrErr++;
         if (CBL && CSL) bothErr++;
         bit_out = ~nib0;
         if (read_1) begin r1Seen++; if (r1Seen == S) bit_out = nib0; end
         if (read_out) begin capSeen++; bit_out = (capSeen == 1) ? nib0 : nib1; end
         if (rsp_valid) lat = cyc;
      end

      checkOutput("latency", 64'(lat), 64'(expLat));
      checkOutput("busyNotReady", 64'(readyAtOne), 64'd0);
      checkOutput("rspData", 64'(rsp_data), 64'(expData));
      checkOutput("rspErr", 64'(rsp_err), 64'(expErr));
      foreach (expCnt[i]) checkOutput(strobeName[i], 64'(obsCnt[i]), 64'(expCnt[i]));
      checkOutput("addrStable", 64'(addrErr), 64'd0);
      checkOutput("cblCslExclusive", 64'(bothErr), 64'd0);
      checkOutput("seeds", 64'(seeds), 64'(expSeeds));
      checkOutput("stochLog", 64'(stoch_log), 64'(expStoch));

      cmd_op = 3'd0;
      cmd_valid = (holdCyc > 0);
      for (int h = 0; h < holdCyc; h++) begin
         @(posedge clk); #1;
         checkOutput("rspHold", {53'd0, rsp_valid, cmd_ready, rsp_err, rsp_data},
                     {53'd0, 1'b1, 1'b0, expErr, expData});
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("afterHandshake", {61'd0, rsp_valid, rsp_err, cmd_ready}, 64'd1);
   endtask

   initial begin
      int w, rspSeen;
      rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_row = 8'h00; cmd_col = 8'h00;
      cmd_data = 8'h00; rsp_ready = 1'b0; bit_out = 4'h0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetAllZero", 64'(allOutputs()), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("readyAfterReset", 64'(cmd_ready), 64'd1);

      $display("[TB] directed commands");
      applyStimulus(3'd1, 8'h12, 8'h34, 8'h00, 4'h0, 4'h0, 0);
      applyStimulus(3'd2, 8'h12, 8'h34, 8'h00, 4'h0, 4'h0, 0);
      applyStimulus(3'd3, 8'h12, 8'h34, 8'hA5, 4'h0, 4'h0, 0);
      applyStimulus(3'd5, 8'h40, 8'h41, 8'h01, 4'h3, 4'hC, 0);
      applyStimulus(3'd4, 8'h05, 8'h06, 8'h00, 4'h9, 4'h0, 1);
      applyStimulus(3'd7, 8'h77, 8'h88, 8'h00, 4'h0, 4'h0, 5);
      applyStimulus(3'd6, 8'h01, 8'h02, 8'h00, 4'h0, 4'h0, 0);
      applyStimulus(3'd0, 8'hFF, 8'h00, 8'h00, 4'h0, 4'h0, 2);
      applyStimulus(3'd5, 8'h10, 8'h20, 8'hFE, 4'hA, 4'h5, 0);

      $display("[TB] random commands");
      for (int n = 0; n < 40; n++) begin
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                       4'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
      end

      $display("[TB] reset during program pulse");
      w = 0;
      while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
      cmd_op = 3'd1; cmd_row = 8'h12; cmd_col = 8'h34; cmd_data = 8'h00; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      w = 0;
      while (!CWL && w < 50) begin @(posedge clk); #1; w++; end
      checkOutput("pulseReached", {62'd0, CWL, CBL}, 64'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("resetMidPulse", 64'(allOutputs()), 64'd0);
      expSeeds = 8'h00; expStoch = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("readyAfterMidReset", {62'd0, cmd_ready, rsp_valid}, 64'd2);
      rspSeen = 0;
      repeat (12) begin @(posedge clk); #1; if (rsp_valid) rspSeen++; end
      checkOutput("noRspAfterReset", 64'(rspSeen), 64'd0);
      applyStimulus(3'd1, 8'h56, 8'h78, 8'h00, 4'h0, 4'h0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
